// File: rtl/wr_nic_wb_regs_if.sv
// Host-side Wishbone classic bus bundle for the WR NIC register bank.
// Signal suffixes follow the slave's point of view (_i driven by master, _o by slave).
interface wr_nic_wb_regs_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wr_nic_wb_regs.sv
// WR NIC control/status register bank: Wishbone classic slave, programmable wait states, W1C IRQ.
// Optional macro WR_NIC_WB_ERR_EN: unmapped offsets and RO writes terminate with wb_err_o.
module wr_nic_wb_regs #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter logic [31:0] ID_VALUE    = 32'hDEADBEEF,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk_125m,
  input  logic              rst_n,
  wr_nic_wb_regs_if.slave   wb,
  input  logic [15:0]       status_i,
  input  logic [3:0]        irq_evt_i,
  output logic [7:0]        ctrl_o,
  output logic              irq_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      r_state, w_state_next;
  logic [3:0]  r_wait_cnt, w_wait_cnt_next;
  logic        r_ack, r_err;
  logic [31:0] r_dat;
  logic [7:0]  r_ctrl;
  logic [31:0] r_scratch;
  logic [3:0]  r_irq_pend, r_irq_mask;
  logic [15:0] r_evt_cnt;
  logic        r_irq;

  logic        w_req, w_hit, w_fire, w_err_term, w_wr;
  logic [3:0]  w_offset, w_clr;
  logic [31:0] w_rdata;

  assign w_req    = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_hit    = w_req & (wb.wb_adr_i[31:6] == BASE_ADDR[31:6]);
  assign w_offset = wb.wb_adr_i[5:2];
  // The transfer completes on the edge leaving ACK, using that edge's bus inputs.
  assign w_fire   = (r_state == ST_ACK) & w_hit;

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          if (WAIT_CYCLES == 0) begin
            w_state_next = ST_ACK;
          end else begin
            w_state_next    = ST_WAIT;
            w_wait_cnt_next = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!w_hit) begin
          w_state_next = ST_IDLE;
        end else if (r_wait_cnt == 4'd0) begin
          w_state_next = ST_ACK;
        end else begin
          w_wait_cnt_next = r_wait_cnt - 4'd1;
        end
      end
      ST_ACK:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = 32'h0;
    case (w_offset)
      4'h0: w_rdata = ID_VALUE;
      4'h1: w_rdata = {24'h0, r_ctrl};
      4'h2: w_rdata = {16'h0, status_i};
      4'h3: w_rdata = r_scratch;
      4'h4: w_rdata = {28'h0, r_irq_pend};
      4'h5: w_rdata = {28'h0, r_irq_mask};
      4'h6: w_rdata = {16'h0, r_evt_cnt};
      default: w_rdata = 32'h0;
    endcase
  end

`ifdef WR_NIC_WB_ERR_EN
  logic w_mapped, w_ro;
  assign w_mapped   = (w_offset <= 4'h6);
  assign w_ro       = (w_offset == 4'h0) | (w_offset == 4'h2) | (w_offset == 4'h6);
  assign w_err_term = ~w_mapped | (wb.wb_we_i & w_ro);
`else
  assign w_err_term = 1'b0;
`endif

  assign w_wr  = w_fire & wb.wb_we_i & ~w_err_term;
  assign w_clr = (w_wr && (w_offset == 4'h4) && wb.wb_sel_i[0]) ? wb.wb_dat_i[3:0] : 4'h0;

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= 32'h0;
    end else begin
      r_ack <= w_fire & ~w_err_term;
      r_err <= w_fire & w_err_term;
      r_dat <= (w_fire && !wb.wb_we_i && !w_err_term) ? w_rdata : 32'h0;
    end
  end

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= 8'h0;
      r_irq_mask <= 4'h0;
      r_irq_pend <= 4'h0;
      r_evt_cnt  <= 16'h0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && (w_offset == 4'h1) && wb.wb_sel_i[0]) r_ctrl <= wb.wb_dat_i[7:0];
      if (w_wr && (w_offset == 4'h5) && wb.wb_sel_i[0]) r_irq_mask <= wb.wb_dat_i[3:0];
      // New events are OR-ed in after the clear so a same-edge set wins.
      r_irq_pend <= (r_irq_pend & ~w_clr) | irq_evt_i;
      if (|irq_evt_i) r_evt_cnt <= r_evt_cnt + 16'd1;
      r_irq <= |(r_irq_pend & r_irq_mask);
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_scratch_lane
      always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
          r_scratch[8*gi +: 8] <= 8'h0;
        end else if (w_wr && (w_offset == 4'h3) && wb.wb_sel_i[gi]) begin
          r_scratch[8*gi +: 8] <= wb.wb_dat_i[8*gi +: 8];
        end
      end
    end
  endgenerate

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_err_o = r_err;
  assign wb.wb_dat_o = r_dat;
  assign ctrl_o      = r_ctrl;
  assign irq_o       = r_irq;

endmodule

// File: tb/tb_wr_nic_wb_regs.sv
// Self-checking bench for wr_nic_wb_regs: WAIT_CYCLES=0 and WAIT_CYCLES=2 instances, scoreboarded reads.
module tb_wr_nic_wb_regs;

`ifdef WR_NIC_WB_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk_125m = 1'b0;
  always #4 clk_125m = ~clk_125m;

  logic        rst_n;
  logic        b_cyc, b_stb, b_we, dut_sel;
  logic [31:0] b_adr, b_dat;
  logic [3:0]  b_sel;
  logic [15:0] status_i;
  logic [3:0]  irq_evt_i;
  logic [3:0]  evt_zero;
  logic [7:0]  ctrl_o, ctrl1_o;
  logic        irq_o, irq1_o;

  wr_nic_wb_regs_if wb0 ();
  wr_nic_wb_regs_if wb1 ();

  assign wb0.wb_cyc_i = b_cyc & ~dut_sel;
  assign wb0.wb_stb_i = b_stb & ~dut_sel;
  assign wb0.wb_we_i  = b_we;
  assign wb0.wb_adr_i = b_adr;
  assign wb0.wb_sel_i = b_sel;
  assign wb0.wb_dat_i = b_dat;
  assign wb1.wb_cyc_i = b_cyc & dut_sel;
  assign wb1.wb_stb_i = b_stb & dut_sel;
  assign wb1.wb_we_i  = b_we;
  assign wb1.wb_adr_i = b_adr;
  assign wb1.wb_sel_i = b_sel;
  assign wb1.wb_dat_i = b_dat;

  logic        m_ack, m_err;
  logic [31:0] m_dat;
  assign m_ack = dut_sel ? wb1.wb_ack_o : wb0.wb_ack_o;
  assign m_err = dut_sel ? wb1.wb_err_o : wb0.wb_err_o;
  assign m_dat = dut_sel ? wb1.wb_dat_o : wb0.wb_dat_o;

  wr_nic_wb_regs #(.WAIT_CYCLES(0)) u_dut (
    .clk_125m (clk_125m),
    .rst_n    (rst_n),
    .wb       (wb0),
    .status_i (status_i),
    .irq_evt_i(irq_evt_i),
    .ctrl_o   (ctrl_o),
    .irq_o    (irq_o)
  );

  wr_nic_wb_regs #(.WAIT_CYCLES(2)) u_dut_w2 (
    .clk_125m (clk_125m),
    .rst_n    (rst_n),
    .wb       (wb1),
    .status_i (status_i),
    .irq_evt_i(evt_zero),
    .ctrl_o   (ctrl1_o),
    .irq_o    (irq1_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // One bus access; exp_lat is the negedge count at which the response is expected (0 = none).
  task automatic wb_access(input logic dsel, input logic [31:0] adr, input logic we,
                           input logic [3:0] sel, input logic [31:0] dat,
                           input logic [31:0] exp_dat, input logic exp_err, input int exp_lat,
                           input int drop_at, input logic [3:0] evt, input string name,
                           output logic [7:0] ctrl_at_resp, output logic irq_at_resp);
    int   lat;
    exp_t e;
    lat = 0;
    if (exp_lat > 0) begin
      e.data = exp_dat; e.err = exp_err; e.chk_data = (!we) | exp_err;
      sb_q.push_back(e);
    end
    @(negedge clk_125m);
    dut_sel = dsel; b_cyc = 1'b1; b_stb = 1'b1; b_we = we;
    b_adr = adr; b_sel = sel; b_dat = dat;
    ctrl_at_resp = ctrl_o; irq_at_resp = irq_o;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk_125m);
      if (m_ack || m_err) begin
        lat = n; ctrl_at_resp = ctrl_o; irq_at_resp = irq_o;
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL %s unexpected_response ack=%0b err=%0b", name, m_ack, m_err);
        end else begin
          e = sb_q.pop_front();
          n_total++;
          if (m_err !== e.err || m_ack !== !e.err)
            $display("FAIL %s resp_kind got ack=%0b err=%0b want err=%0b", name, m_ack, m_err, e.err);
          else n_pass++;
          if (e.chk_data) begin
            n_total++;
            if (m_dat !== e.data) $display("FAIL %s data got %08h want %08h", name, m_dat, e.data);
            else n_pass++;
          end
        end
        break;
      end
      if (n == 1) irq_evt_i = evt; else irq_evt_i = 4'h0;
      if (n == drop_at) begin b_cyc = 1'b0; b_stb = 1'b0; end
    end
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0; irq_evt_i = 4'h0;
    n_total++;
    if (lat !== exp_lat) $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
    else n_pass++;
    if (exp_lat > 0 && lat == 0) sb_q.delete();
    if (lat > 0) begin
      @(negedge clk_125m);
      n_total++;
      if (m_ack !== 1'b0 || m_err !== 1'b0)
        $display("FAIL %s resp_width ack=%0b err=%0b want 0 0", name, m_ack, m_err);
      else n_pass++;
    end
    $display("txn %-16s dut=%0d adr=%08h we=%0b sel=%04b dat=%08h lat=%0d", name, dsel, adr, we, sel, dat, lat);
  endtask

  task automatic rd0(input logic [31:0] adr, input logic [31:0] exp, input string name);
    logic [7:0] c; logic q;
    wb_access(1'b0, adr, 1'b0, 4'hF, 32'h0, exp, 1'b0, 2, 0, 4'h0, name, c, q);
  endtask

  task automatic wr0(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input string name);
    logic [7:0] c; logic q;
    wb_access(1'b0, adr, 1'b1, sel, dat, 32'h0, 1'b0, 2, 0, 4'h0, name, c, q);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dut_sel = 1'b0; b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
    b_adr = 32'h0; b_sel = 4'h0; b_dat = 32'h0; status_i = 16'h0;
    irq_evt_i = 4'h0; evt_zero = 4'h0;
    repeat (3) @(negedge clk_125m);
    n_total++;
    if (wb0.wb_ack_o !== 1'b0 || wb0.wb_err_o !== 1'b0 || wb0.wb_dat_o !== 32'h0)
      $display("FAIL reset_bus ack=%0b err=%0b dat=%08h want 0", wb0.wb_ack_o, wb0.wb_err_o, wb0.wb_dat_o);
    else n_pass++;
    n_total++;
    if (ctrl_o !== 8'h0 || irq_o !== 1'b0)
      $display("FAIL reset_outs ctrl=%02h irq=%0b want 00 0", ctrl_o, irq_o);
    else n_pass++;
    @(negedge clk_125m) rst_n = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    @(negedge clk_125m);
    dut_sel = 1'b1; b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b1; b_adr = 32'h0000_100C;
    b_sel = 4'hF; b_dat = 32'h5A5A5A5A;
    @(negedge clk_125m) rst_n = 1'b0;
    repeat (3) begin @(negedge clk_125m); if (m_ack || m_err) acks++; end
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0; rst_n = 1'b1;
    repeat (6) begin @(negedge clk_125m); if (m_ack || m_err) acks++; end
    n_total++;
    if (acks !== 0) $display("FAIL reset_mid_no_ack got %0d responses want 0", acks);
    else n_pass++;
    $display("txn reset_mid responses=%0d", acks);
  endtask

  task automatic test_basic_reads();
    status_i = 16'hBEEF;
    rd0(32'h0000_1000, 32'hDEADBEEF, "rd_id");
    rd0(32'h0000_1004, 32'h0, "rd_ctrl_rst");
    rd0(32'h0000_1010, 32'h0, "rd_pend_rst");
    rd0(32'h0000_1014, 32'h0, "rd_mask_rst");
    rd0(32'h0000_1018, 32'h0, "rd_evtcnt_rst");
    rd0(32'h0000_1008, 32'h0000BEEF, "rd_status");
    rd0(32'h0000_100C, 32'h0, "rd_scratch_rst");
    n_total++;
    if (irq_o !== 1'b0) $display("FAIL irq_after_reset got %0b want 0", irq_o);
    else n_pass++;
  endtask

  task automatic test_byte_lanes();
    logic [7:0] c; logic q;
    wr0(32'h0000_100C, 32'hCAFEF00D, 4'b0101, "wr_scratch_sel5");
    rd0(32'h0000_100C, 32'h00FE000D, "rd_scratch_sel5");
    wr0(32'h0000_100C, 32'h12345678, 4'b0000, "wr_scratch_sel0");
    rd0(32'h0000_100C, 32'h00FE000D, "rd_scratch_sel0");
    wr0(32'h0000_100F, 32'h99000000, 4'b1000, "wr_scratch_lane3");
    rd0(32'h0000_100E, 32'h99FE000D, "rd_scratch_lane3");
    wb_access(1'b0, 32'h0000_1004, 1'b1, 4'hF, 32'h000000A5, 32'h0, 1'b0, 2, 0, 4'h0, "wr_ctrl", c, q);
    n_total++;
    if (c !== 8'hA5) $display("FAIL ctrl_on_ack got %02h want a5", c);
    else n_pass++;
    wr0(32'h0000_1004, 32'hFFFFFF3C, 4'b1110, "wr_ctrl_hilanes");
    n_total++;
    if (ctrl_o !== 8'hA5) $display("FAIL ctrl_hilanes got %02h want a5", ctrl_o);
    else n_pass++;
    rd0(32'h0000_1004, 32'h000000A5, "rd_ctrl");
  endtask

  task automatic test_back_to_back();
    int   first, second, cnt;
    exp_t e;
    first = 0; second = 0; cnt = 0;
    e.data = 32'hDEADBEEF; e.err = 1'b0; e.chk_data = 1'b1;
    sb_q.push_back(e); sb_q.push_back(e);
    @(negedge clk_125m);
    dut_sel = 1'b0; b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b0; b_adr = 32'h0000_1000; b_sel = 4'hF;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk_125m);
      if (m_ack) begin
        cnt++;
        if (cnt == 1) first = n; else if (cnt == 2) second = n;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          n_total++;
          if (m_dat !== e.data) $display("FAIL b2b_data got %08h want %08h", m_dat, e.data);
          else n_pass++;
        end
        if (cnt == 2) begin b_cyc = 1'b0; b_stb = 1'b0; end
      end
    end
    b_cyc = 1'b0; b_stb = 1'b0;
    sb_q.delete();
    n_total++;
    if (first !== 2 || second !== 4 || cnt !== 2)
      $display("FAIL b2b_timing got acks at %0d,%0d count %0d want 2,4 count 2", first, second, cnt);
    else n_pass++;
    $display("txn back_to_back acks=%0d at %0d,%0d", cnt, first, second);
  endtask

  task automatic test_irq();
    logic [7:0] c; logic q;
    @(negedge clk_125m) irq_evt_i = 4'b0010;
    @(negedge clk_125m) irq_evt_i = 4'b0000;
    rd0(32'h0000_1010, 32'h2, "rd_pend_evt");
    wb_access(1'b0, 32'h0000_1014, 1'b1, 4'hF, 32'h2, 32'h0, 1'b0, 2, 0, 4'h0, "wr_mask", c, q);
    n_total++;
    if (q !== 1'b0) $display("FAIL irq_mask_ack_edge got %0b want 0", q);
    else n_pass++;
    n_total++;
    if (irq_o !== 1'b1) $display("FAIL irq_after_mask got %0b want 1", irq_o);
    else n_pass++;
    wb_access(1'b0, 32'h0000_1010, 1'b1, 4'hF, 32'h2, 32'h0, 1'b0, 2, 0, 4'b0010, "w1c_vs_evt", c, q);
    rd0(32'h0000_1010, 32'h2, "rd_pend_setwins");
    n_total++;
    if (irq_o !== 1'b1) $display("FAIL irq_setwins got %0b want 1", irq_o);
    else n_pass++;
    wb_access(1'b0, 32'h0000_1010, 1'b1, 4'hF, 32'h2, 32'h0, 1'b0, 2, 0, 4'h0, "w1c_clear", c, q);
    n_total++;
    if (q !== 1'b1) $display("FAIL irq_clear_ack_edge got %0b want 1", q);
    else n_pass++;
    n_total++;
    if (irq_o !== 1'b0) $display("FAIL irq_after_clear got %0b want 0", irq_o);
    else n_pass++;
    rd0(32'h0000_1010, 32'h0, "rd_pend_clear");
    rd0(32'h0000_1018, 32'h2, "rd_evtcnt");
  endtask

  task automatic test_unmapped();
    logic [7:0] c; logic q;
    wb_access(1'b0, 32'h0000_1020, 1'b0, 4'hF, 32'h0, 32'h0, ERR_EN, 2, 0, 4'h0, "rd_unmapped", c, q);
    wb_access(1'b0, 32'h0000_103C, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0, ERR_EN, 2, 0, 4'h0, "wr_unmapped", c, q);
    wb_access(1'b0, 32'h0000_1000, 1'b1, 4'hF, 32'h0, 32'h0, ERR_EN, 2, 0, 4'h0, "wr_id_ro", c, q);
    wb_access(1'b0, 32'h0000_1018, 1'b1, 4'hF, 32'h0, 32'h0, ERR_EN, 2, 0, 4'h0, "wr_evtcnt_ro", c, q);
    rd0(32'h0000_1000, 32'hDEADBEEF, "rd_id_after_wr");
    rd0(32'h0000_1018, 32'h2, "rd_evtcnt_after");
  endtask

  task automatic test_no_hit();
    logic [7:0] c; logic q;
    wb_access(1'b0, 32'h0000_2000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 0, 0, 4'h0, "rd_nohit", c, q);
    wb_access(1'b0, 32'h0000_200C, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0, 0, 0, 4'h0, "wr_nohit", c, q);
    rd0(32'h0000_100C, 32'h99FE000D, "rd_scratch_nohit");
  endtask

  task automatic test_wait_states();
    logic [7:0] c; logic q;
    wb_access(1'b1, 32'h0000_1000, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 4, 0, 4'h0, "w2_rd_id", c, q);
    wb_access(1'b1, 32'h0000_100C, 1'b1, 4'hF, 32'h11111111, 32'h0, 1'b0, 4, 0, 4'h0, "w2_wr_scratch", c, q);
    wb_access(1'b1, 32'h0000_100C, 1'b1, 4'hF, 32'h22222222, 32'h0, 1'b0, 0, 1, 4'h0, "w2_abort", c, q);
    wb_access(1'b1, 32'h0000_100C, 1'b0, 4'hF, 32'h0, 32'h11111111, 1'b0, 4, 0, 4'h0, "w2_rd_scratch", c, q);
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_basic_reads();
    test_byte_lanes();
    test_back_to_back();
    test_irq();
    test_unmapped();
    test_no_hit();
    test_wait_states();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
